// File: rtl/sq_rd_arbiter_pkg.sv
// Shared sq_rd/cq_rd descriptor type and stream encodings for the read-queue arbiter.
package sq_rd_arbiter_pkg;

   localparam int unsigned OPCODE_BITS = 5;
   localparam int unsigned STRM_BITS   = 2;
   localparam int unsigned DEST_BITS   = 3;
   localparam int unsigned PID_BITS    = 6;
   localparam int unsigned VADDR_BITS  = 48;
   localparam int unsigned LEN_BITS    = 28;

   localparam logic [STRM_BITS-1:0] STRM_CARD = 2'd0;
   localparam logic [STRM_BITS-1:0] STRM_HOST = 2'd1;

   typedef struct packed {
      logic [OPCODE_BITS-1:0] opcode;
      logic [STRM_BITS-1:0]   strm;
      logic [DEST_BITS-1:0]   dest;
      logic [PID_BITS-1:0]    pid;
      logic                   last;
      logic [VADDR_BITS-1:0]  vaddr;
      logic [LEN_BITS-1:0]    len;
   } req_t;

endpackage

// File: rtl/sq_rd_arbiter.sv
// Round-robin sharing of one sq_rd/cq_rd pair among N_REQ stream readers,
// with per-requester outstanding limits and dest-based completion routing.
module sq_rd_arbiter
   import sq_rd_arbiter_pkg::*;
#(
   parameter int unsigned          N_REQ           = 4,
   parameter logic [STRM_BITS-1:0] STRM            = STRM_HOST,
   parameter int unsigned          DEST_BASE       = 0,
   parameter int unsigned          MAX_OUTSTANDING = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [N_REQ-1:0]     req_valid,
   output logic [N_REQ-1:0]     req_ready,
   input  req_t [N_REQ-1:0]     req_data,
   output logic                 sq_valid,
   input  logic                 sq_ready,
   output req_t                 sq_data,
   input  logic                 cq_valid,
   output logic                 cq_ready,
   input  req_t                 cq_data,
   output logic [N_REQ-1:0]     cpl_valid,
   output req_t [N_REQ-1:0]     cpl_data,
   output logic                 idle,
   output logic                 err_unexpected_cq
);

   localparam int unsigned     CNT_W   = $clog2(MAX_OUTSTANDING + 1);
   localparam int unsigned     PTR_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);

   if (DEST_BASE + N_REQ > 8) begin : g_bad_dest_range
      $error("sq_rd_arbiter: DEST_BASE+N_REQ exceeds the 3-bit dest space");
   end

   logic             slot_vld_q, slot_vld_d;
   req_t             slot_q, slot_d;
   logic [PTR_W-1:0] ptr_q, ptr_d;
   logic [CNT_W-1:0] cnt_q [N_REQ];
   logic [CNT_W-1:0] cnt_d [N_REQ];
   logic             err_q, err_d;
   logic             idle_q, idle_d;

   logic             slot_free;
   logic             found;
   logic             accept;
   logic [PTR_W-1:0] win;
   logic [N_REQ-1:0] elig;
   logic [N_REQ-1:0] match;

   // Eligibility and completion dest/strm decode.
   always_comb begin
      elig  = '0;
      match = '0;
      for (int i = 0; i < int'(N_REQ); i++) begin
         elig[i]  = req_valid[i] && (cnt_q[i] < CNT_MAX);
         match[i] = cq_valid && (cq_data.strm == STRM) &&
                    (cq_data.dest == DEST_BITS'(DEST_BASE + 32'(i)));
      end
   end

   // Round-robin search starting one past the last winner.
   always_comb begin
      slot_free = !slot_vld_q || sq_ready;
      found     = 1'b0;
      win       = '0;
      for (int unsigned k = 1; k <= N_REQ; k++) begin
         if (!found && elig[PTR_W'((32'(ptr_q) + k) % N_REQ)]) begin
            found = 1'b1;
            win   = PTR_W'((32'(ptr_q) + k) % N_REQ);
         end
      end
      accept    = slot_free && found;
      req_ready = '0;
      if (accept) begin
         req_ready[win] = 1'b1;
      end
   end

   // Output slot and pointer next state.
   always_comb begin
      slot_vld_d = slot_vld_q;
      slot_d     = slot_q;
      ptr_d      = ptr_q;
      if (accept) begin
         slot_vld_d  = 1'b1;
         slot_d      = req_data[win];
         slot_d.dest = DEST_BITS'(DEST_BASE + 32'(win));
         ptr_d       = win;
      end else if (sq_ready) begin
         slot_vld_d = 1'b0;
      end
   end

   // Outstanding counters; a simultaneous accept and completion cancel out.
   always_comb begin
      err_d  = err_q;
      idle_d = !slot_vld_d;
      for (int i = 0; i < int'(N_REQ); i++) begin
         cnt_d[i] = cnt_q[i];
         if (req_ready[i] && !match[i]) begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
         end else if (match[i] && !req_ready[i]) begin
            if (cnt_q[i] != '0) begin
               cnt_d[i] = cnt_q[i] - CNT_W'(1);
            end else begin
               err_d = 1'b1;
            end
         end
         if (cnt_d[i] != '0) begin
            idle_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         slot_vld_q <= 1'b0;
         ptr_q      <= PTR_W'(N_REQ - 1);
         err_q      <= 1'b0;
         idle_q     <= 1'b1;
         for (int i = 0; i < int'(N_REQ); i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         slot_vld_q <= slot_vld_d;
         ptr_q      <= ptr_d;
         err_q      <= err_d;
         idle_q     <= idle_d;
         for (int i = 0; i < int'(N_REQ); i++) begin
            cnt_q[i] <= cnt_d[i];
         end
      end
   end

   // Descriptor payload needs no reset; its valid qualifies it.
   always_ff @(posedge clk) begin
      slot_q <= slot_d;
   end

   always_comb begin
      for (int i = 0; i < int'(N_REQ); i++) begin
         cpl_data[i] = cq_data;
      end
   end

   assign cpl_valid         = match;
   assign sq_valid          = slot_vld_q;
   assign sq_data           = slot_q;
   assign cq_ready          = 1'b1;
   assign idle              = idle_q;
   assign err_unexpected_cq = err_q;

   a_sq_data_stable: assert property (@(posedge clk) disable iff (!rst_n)
      (sq_valid && !sq_ready) |=> $stable(sq_data));

   a_req_ready_onehot0: assert property (@(posedge clk) $onehot0(req_ready));

endmodule

// File: tb/tb_sq_rd_arbiter.sv
// Directed, table-driven checks of grant order, back-pressure, outstanding limits,
// completion routing, the sticky error flag and mid-operation reset.
module tb_sq_rd_arbiter;
   import sq_rd_arbiter_pkg::*;

   localparam int unsigned N = 4;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [N-1:0] req_valid;
   logic [N-1:0] req_ready;
   req_t [N-1:0] req_data;
   logic         sq_valid;
   logic         sq_ready;
   req_t         sq_data;
   logic         cq_valid;
   logic         cq_ready;
   req_t         cq_data;
   logic [N-1:0] cpl_valid;
   req_t [N-1:0] cpl_data;
   logic         idle;
   logic         err_unexpected_cq;

   always #5 clk = ~clk;

   sq_rd_arbiter #(
      .N_REQ          (N),
      .STRM           (STRM_HOST),
      .DEST_BASE      (0),
      .MAX_OUTSTANDING(4)
   ) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .req_valid        (req_valid),
      .req_ready        (req_ready),
      .req_data         (req_data),
      .sq_valid         (sq_valid),
      .sq_ready         (sq_ready),
      .sq_data          (sq_data),
      .cq_valid         (cq_valid),
      .cq_ready         (cq_ready),
      .cq_data          (cq_data),
      .cpl_valid        (cpl_valid),
      .cpl_data         (cpl_data),
      .idle             (idle),
      .err_unexpected_cq(err_unexpected_cq)
   );

   typedef struct {
      string        name;
      logic         rst_n;
      logic [N-1:0] rv;
      logic         sq_ready;
      logic         cqv;
      logic [2:0]   cd;
      logic [1:0]   cs;
      logic [N-1:0] e_rr;
      logic         e_sqv;
      int           e_src;
      logic [N-1:0] e_cpl;
      logic         e_idle;
      logic         e_err;
   } vec_t;

   vec_t vq[$];
   int   checks   = 0;
   int   failures = 0;

   // Requester descriptors carry a deliberately wrong dest so the overwrite is visible.
   function automatic req_t req_word(int i);
      req_t r;
      r.opcode = 5'(i + 1);
      r.strm   = STRM_HOST;
      r.dest   = 3'(7 - i);
      r.pid    = 6'(i + 5);
      r.last   = 1'b1;
      r.vaddr  = 48'h1000 * 48'(i + 1) + 48'hABC;
      r.len    = 28'(64 * (i + 1));
      return r;
   endfunction

   function automatic req_t exp_sq(int src);
      req_t r;
      r      = req_word(src);
      r.dest = 3'(src);
      return r;
   endfunction

   function automatic req_t cq_word(logic [2:0] d, logic [1:0] s, int tag);
      req_t r;
      r.opcode = 5'd0;
      r.strm   = s;
      r.dest   = d;
      r.pid    = 6'h2A;
      r.last   = 1'b1;
      r.vaddr  = 48'hDEAD_0000 + 48'(tag);
      r.len    = 28'h10;
      return r;
   endfunction

   function automatic void add(string nm, logic r, logic [N-1:0] rv, logic sqr,
                               logic cqv, logic [2:0] cd, logic [1:0] cs,
                               logic [N-1:0] rr, logic sqv, int src,
                               logic [N-1:0] cpl, logic idl, logic err);
      vec_t v;
      v.name = nm;   v.rst_n = r;     v.rv = rv;       v.sq_ready = sqr;
      v.cqv = cqv;   v.cd = cd;       v.cs = cs;       v.e_rr = rr;
      v.e_sqv = sqv; v.e_src = src;   v.e_cpl = cpl;   v.e_idle = idl;
      v.e_err = err;
      vq.push_back(v);
   endfunction

   task automatic chk(string what, logic [127:0] act, logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", what, act, exp);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [1:0] h;
      h = STRM_HOST;

      // Reset state.
      add("rst_state", 1, 4'h0, 1, 0, 0, h, 4'h0, 0, 0, 4'h0, 1, 0);
      // Full-throughput round robin until every requester saturates.
      for (int k = 0; k < 16; k++)
         add("rr", 1, 4'hF, 1, 0, 0, h, 4'(1 << (k % 4)), k > 0, (k + 3) % 4, 4'h0, k == 0, 0);
      add("sat_a", 1, 4'hF, 1, 0, 0, h, 4'h0, 1, 3, 4'h0, 0, 0);
      add("sat_b", 1, 4'hF, 1, 0, 0, h, 4'h0, 0, 0, 4'h0, 0, 0);
      // One completion frees requester 1 at its limit.
      add("cq1",      1, 4'hF, 1, 1, 1, h, 4'h0,    0, 0, 4'b0010, 0, 0);
      add("regrant1", 1, 4'hF, 1, 0, 0, h, 4'b0010, 0, 0, 4'h0,    0, 0);
      add("sat_c",    1, 4'hF, 1, 0, 0, h, 4'h0,    1, 1, 4'h0,    0, 0);
      add("sat_d",    1, 4'hF, 1, 0, 0, h, 4'h0,    0, 0, 4'h0,    0, 0);
      for (int k = 0; k < 16; k++)
         add("drain", 1, 4'h0, 1, 1, 3'(k / 4), h, 4'h0, 0, 0, 4'(1 << (k / 4)), 0, 0);
      add("drained", 1, 4'h0, 1, 0, 0, h, 4'h0, 0, 0, 4'h0, 1, 0);
      // Accept and completion for requester 0 in the same cycle at cnt=2.
      add("acc0_a",    1, 4'b0001, 1, 0, 0, h, 4'b0001, 0, 0, 4'h0,    1, 0);
      add("acc0_b",    1, 4'b0001, 1, 0, 0, h, 4'b0001, 1, 0, 4'h0,    0, 0);
      add("acc_cpl0",  1, 4'b0001, 1, 1, 0, h, 4'b0001, 1, 0, 4'b0001, 0, 0);
      add("hold0",     1, 4'h0,    1, 0, 0, h, 4'h0,    1, 0, 4'h0,    0, 0);
      add("cnt0_a",    1, 4'h0,    1, 1, 0, h, 4'h0,    0, 0, 4'b0001, 0, 0);
      add("cnt0_b",    1, 4'h0,    1, 1, 0, h, 4'h0,    0, 0, 4'b0001, 0, 0);
      add("cnt0_zero", 1, 4'h0,    1, 0, 0, h, 4'h0,    0, 0, 4'h0,    1, 0);
      // Unexpected, unowned and wrong-stream completions.
      add("unexp3",     1, 4'h0, 1, 1, 3, h,         4'h0, 0, 0, 4'b1000, 1, 0);
      add("unowned6",   1, 4'h0, 1, 1, 6, h,         4'h0, 0, 0, 4'h0,    1, 1);
      add("badstrm",    1, 4'h0, 1, 1, 1, STRM_CARD, 4'h0, 0, 0, 4'h0,    1, 1);
      add("err_sticky", 1, 4'h0, 1, 0, 0, h,         4'h0, 0, 0, 4'h0,    1, 1);
      // Back-pressure: slot holds requester 2 for five stalled cycles.
      add("stall_acc", 1, 4'b0100, 0, 0, 0, h, 4'b0100, 0, 0, 4'h0, 1, 1);
      for (int k = 0; k < 5; k++)
         add("stall", 1, 4'b1011, 0, 0, 0, h, 4'h0, 1, 2, 4'h0, 0, 1);
      add("stall_rel",  1, 4'h0, 1, 0, 0, h, 4'h0, 1, 2, 4'h0,    0, 1);
      add("stall_done", 1, 4'h0, 1, 0, 0, h, 4'h0, 0, 0, 4'h0,    0, 1);
      add("cpl2",       1, 4'h0, 1, 1, 2, h, 4'h0, 0, 0, 4'b0100, 0, 1);
      add("idle2",      1, 4'h0, 1, 0, 0, h, 4'h0, 0, 0, 4'h0,    1, 1);
      // Build cnt={1,2,0,3} with a busy slot, then reset mid-operation.
      add("rs_a",      1, 4'b1011, 1, 0, 0, h, 4'b1000, 0, 0, 4'h0,    1, 1);
      add("rs_b",      1, 4'b1011, 1, 0, 0, h, 4'b0001, 1, 3, 4'h0,    0, 1);
      add("rs_c",      1, 4'b1011, 1, 0, 0, h, 4'b0010, 1, 0, 4'h0,    0, 1);
      add("rs_d",      1, 4'b1000, 1, 0, 0, h, 4'b1000, 1, 1, 4'h0,    0, 1);
      add("rs_e",      1, 4'b1000, 1, 0, 0, h, 4'b1000, 1, 3, 4'h0,    0, 1);
      add("rs_f",      1, 4'b0010, 1, 0, 0, h, 4'b0010, 1, 3, 4'h0,    0, 1);
      add("rs_g",      1, 4'h0,    0, 0, 0, h, 4'h0,    1, 1, 4'h0,    0, 1);
      add("rs_assert", 0, 4'h0,    0, 0, 0, h, 4'h0,    1, 1, 4'h0,    0, 1);
      add("rs_post",   1, 4'h0,    1, 0, 0, h, 4'h0,    0, 0, 4'h0,    1, 0);
      add("rs_prio",   1, 4'hF,    1, 0, 0, h, 4'b0001, 0, 0, 4'h0,    1, 0);
      add("rs_unexp",  1, 4'h0,    1, 1, 2, h, 4'h0,    1, 0, 4'b0100, 0, 0);
      add("rs_cpl0",   1, 4'h0,    1, 1, 0, h, 4'h0,    0, 0, 4'b0001, 0, 1);
      add("rs_idle",   1, 4'h0,    1, 0, 0, h, 4'h0,    0, 0, 4'h0,    1, 1);

      rst_n     = 1'b0;
      req_valid = '0;
      sq_ready  = 1'b0;
      cq_valid  = 1'b0;
      cq_data   = cq_word(3'd0, STRM_HOST, 0);
      for (int i = 0; i < int'(N); i++) req_data[i] = req_word(i);
      repeat (2) @(posedge clk);

      for (int r = 0; r < vq.size(); r++) begin
         vec_t v;
         req_t cw;
         v = vq[r];
         @(negedge clk);
         cw        = cq_word(v.cd, v.cs, r);
         rst_n     = v.rst_n;
         req_valid = v.rv;
         sq_ready  = v.sq_ready;
         cq_valid  = v.cqv;
         cq_data   = cw;
         #1;
         chk($sformatf("%0d %s req_ready", r, v.name), 128'(req_ready), 128'(v.e_rr));
         chk($sformatf("%0d %s sq_valid", r, v.name), 128'(sq_valid), 128'(v.e_sqv));
         if (v.e_sqv)
            chk($sformatf("%0d %s sq_data", r, v.name), 128'(sq_data), 128'(exp_sq(v.e_src)));
         chk($sformatf("%0d %s cpl_valid", r, v.name), 128'(cpl_valid), 128'(v.e_cpl));
         for (int i = 0; i < int'(N); i++)
            if (v.e_cpl[i])
               chk($sformatf("%0d %s cpl_data%0d", r, v.name, i), 128'(cpl_data[i]), 128'(cw));
         chk($sformatf("%0d %s idle", r, v.name), 128'(idle), 128'(v.e_idle));
         chk($sformatf("%0d %s err", r, v.name), 128'(err_unexpected_cq), 128'(v.e_err));
         chk($sformatf("%0d %s cq_ready", r, v.name), 128'(cq_ready), 128'(1));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
